conversor_bcd: RTL and testbench

Sequential binary-to-BCD converter (shift-and-add-3) that turns a WIDTH-bit measurement, such as an ultrasonic distance count, into hundreds/tens/units digits. It also drives the digit-significance flags C, De and U. It sits upstream of the seven-segment digit multiplexer, which consumes `centenas`, `decenas`, `unidades`, `C`, `De` and `U` directly. Inputs above 999 saturate to 999 and raise an overflow flag.

---
 rtl/conversor_bcd.sv | 154 +++++++++++++++
 tb/tb_conversor_bcd.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/conversor_bcd.sv
// -----------------------------------------------------------------------------
// conversor_bcd
//
// Sequential binary-to-BCD converter using the shift-and-add-3 (double dabble)
// method. A WIDTH-bit unsigned measurement is saturated to 999 and turned
// into hundreds/tens/units digits for the seven-segment digit multiplexer,
// together with the digit-significance flags it relies on.
//
// Ports:
//   CLK         single clock, rising-edge
//   RESET_N     asynchronous active-low reset
//   binario     value to convert, sampled only when a start is accepted
//   iniciar     start request, accepted only while idle
//   centenas    hundreds digit (BCD)
//   decenas     tens digit (BCD)
//   unidades    units digit (BCD)
//   C           result >= 100
//   De          result >= 10 (always set when C is set)
//   U           a valid result is present (set after any conversion)
//   sobrecarga  last converted input exceeded 999
//   ocupado     conversion in progress
//   listo       one-cycle pulse, coincides with result update
//
// Latency is WIDTH clocks from the accepted start to the listo cycle; a new
// start may be accepted in the listo cycle itself.
// -----------------------------------------------------------------------------
module conversor_bcd #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [WIDTH-1:0] binario,
  input  logic             iniciar,
  output logic [3:0]       centenas,
  output logic [3:0]       decenas,
  output logic [3:0]       unidades,
  output logic             C,
  output logic             De,
  output logic             U,
  output logic             sobrecarga,
  output logic             ocupado,
  output logic             listo
);

  typedef enum logic {
    REPOSO,
    DESPLAZA
  } estado_t;

  estado_t estado, estado_sig;

  // Working registers of the conversion.
  logic [WIDTH-1:0] bin_sr;   // binary shift register, MSB shifts into BCD
  logic [11:0]      bcd;      // three-digit BCD accumulator
  logic [3:0]       cuenta;   // shifts performed so far
  logic             ovf;      // input was above 999

  // Combinational helpers.
  logic [15:0]      bin_ext;
  logic             ovf_in;
  logic [WIDTH-1:0] bin_sat;
  logic [11:0]      bcd_adj;
  logic [11:0]      bcd_shift;
  logic             ultimo;
  logic             arranque;

  // Saturation happens before conversion so the 12-bit accumulator can never
  // overflow. The comparison is done on a widened copy so it stays valid for
  // widths narrower than 10 bits, where it simply never fires.
  always_comb begin
    bin_ext = 16'(binario);
    ovf_in  = (bin_ext > 16'd999);
    bin_sat = ovf_in ? WIDTH'(999) : binario;
  end

  // Add-3 correction on every nibble >= 5, then the combined left shift.
  always_comb begin
    bcd_adj = bcd;
    for (int unsigned i = 0; i < 3; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
    bcd_shift = {bcd_adj[10:0], bin_sr[WIDTH-1]};
  end

  always_comb begin
    ultimo   = (cuenta == 4'(WIDTH - 1));
    arranque = (estado == REPOSO) && iniciar;
    ocupado  = (estado == DESPLAZA);
  end

  // State register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      estado <= REPOSO;
    end else begin
      estado <= estado_sig;
    end
  end

  // Next-state logic. Starts arriving while busy are simply not looked at.
  always_comb begin
    estado_sig = estado;
    case (estado)
      REPOSO:   if (iniciar) estado_sig = DESPLAZA;
      DESPLAZA: if (ultimo)  estado_sig = REPOSO;
      default:  estado_sig = REPOSO;
    endcase
  end

  // Datapath and result registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      bin_sr     <= '0;
      bcd        <= '0;
      cuenta     <= '0;
      ovf        <= 1'b0;
      centenas   <= '0;
      decenas    <= '0;
      unidades   <= '0;
      C          <= 1'b0;
      De         <= 1'b0;
      U          <= 1'b0;
      sobrecarga <= 1'b0;
      listo      <= 1'b0;
    end else begin
      listo <= 1'b0;
      if (arranque) begin
        bin_sr <= bin_sat;
        ovf    <= ovf_in;
        bcd    <= '0;
        cuenta <= '0;
      end else if (estado == DESPLAZA) begin
        bcd    <= bcd_shift;
        bin_sr <= bin_sr << 1;
        cuenta <= cuenta + 4'd1;
        // Results are taken from the post-shift value of the final step so
        // the outputs never expose a partially converted accumulator.
        if (ultimo) begin
          centenas   <= bcd_shift[11:8];
          decenas    <= bcd_shift[7:4];
          unidades   <= bcd_shift[3:0];
          C          <= |bcd_shift[11:8];
          De         <= |bcd_shift[11:4];
          U          <= 1'b1;
          sobrecarga <= ovf;
          listo      <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_conversor_bcd.sv
module tb_conversor_bcd;

  localparam int unsigned WIDTH = 10;

  logic             CLK = 1'b0;
  logic             RESET_N;
  logic [WIDTH-1:0] binario;
  logic             iniciar;
  logic [3:0]       centenas, decenas, unidades;
  logic             C, De, U, sobrecarga, ocupado, listo;

  conversor_bcd #(.WIDTH(WIDTH)) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .binario    (binario),
    .iniciar    (iniciar),
    .centenas   (centenas),
    .decenas    (decenas),
    .unidades   (unidades),
    .C          (C),
    .De         (De),
    .U          (U),
    .sobrecarga (sobrecarga),
    .ocupado    (ocupado),
    .listo      (listo)
  );

  initial forever #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a countdown of remaining clocks plus decimal arithmetic.
  // ---------------------------------------------------------------------------
  int m_rem = 0;
  int m_val = 0;
  bit m_ovf = 0;
  int e_cen = 0, e_dec = 0, e_uni = 0;
  bit e_C = 0, e_De = 0, e_U = 0, e_sob = 0, e_listo = 0;

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      m_rem = 0; m_val = 0; m_ovf = 0;
      e_cen = 0; e_dec = 0; e_uni = 0;
      e_C = 0; e_De = 0; e_U = 0; e_sob = 0; e_listo = 0;
    end else begin
      e_listo = 0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          e_cen   = m_val / 100;
          e_dec   = (m_val / 10) % 10;
          e_uni   = m_val % 10;
          e_C     = (m_val >= 100);
          e_De    = (m_val >= 10);
          e_U     = 1;
          e_sob   = m_ovf;
          e_listo = 1;
        end
      end else if (iniciar) begin
        m_ovf = (int'(binario) > 999);
        m_val = m_ovf ? 999 : int'(binario);
        m_rem = WIDTH;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    check("listo",      int'(listo),      int'(e_listo));
    check("ocupado",    int'(ocupado),    int'(m_rem > 0));
    check("centenas",   int'(centenas),   e_cen);
    check("decenas",    int'(decenas),    e_dec);
    check("unidades",   int'(unidades),   e_uni);
    check("flag_C",     int'(C),          int'(e_C));
    check("flag_De",    int'(De),         int'(e_De));
    check("flag_U",     int'(U),          int'(e_U));
    check("sobrecarga", int'(sobrecarga), int'(e_sob));
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus with literal expectations.
  // ---------------------------------------------------------------------------
  task automatic start(input int v);
    @(negedge CLK);
    binario = WIDTH'(v);
    iniciar = 1'b1;
    @(negedge CLK);
    iniciar = 1'b0;
  endtask

  // Returns the number of negedges until listo is seen, -1 on timeout.
  task automatic wait_listo(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge CLK);
      if (listo === 1'b1) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) check("listo_timeout", 0, 1);
  endtask

  task automatic check_result(input string tag, input int ec, input int ed, input int eu,
                              input int eC, input int eDe, input int eovf);
    check({tag, "_cen"}, int'(centenas), ec);
    check({tag, "_dec"}, int'(decenas), ed);
    check({tag, "_uni"}, int'(unidades), eu);
    check({tag, "_C"}, int'(C), eC);
    check({tag, "_De"}, int'(De), eDe);
    check({tag, "_U"}, int'(U), 1);
    check({tag, "_ovf"}, int'(sobrecarga), eovf);
  endtask

  task automatic conv(input string tag, input int v, input int ec, input int ed, input int eu,
                      input int eC, input int eDe, input int eovf);
    int lat;
    start(v);
    wait_listo(lat);
    check({tag, "_latency"}, lat, 10);
    check_result(tag, ec, ed, eu, eC, eDe, eovf);
    @(negedge CLK);
    check({tag, "_listo_drop"}, int'(listo), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    RESET_N = 1'b1;
    iniciar = 1'b0;
    binario = '0;
    #1 RESET_N = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_cen", int'(centenas), 0);
    check("rst_dec", int'(decenas), 0);
    check("rst_uni", int'(unidades), 0);
    check("rst_U", int'(U), 0);
    check("rst_De", int'(De), 0);
    check("rst_C", int'(C), 0);
    check("rst_ocupado", int'(ocupado), 0);
    check("rst_listo", int'(listo), 0);
    #2 RESET_N = 1'b1;

    conv("v0",    0,    0, 0, 0, 0, 0, 0);
    conv("v7",    7,    0, 0, 7, 0, 0, 0);
    conv("v42",   42,   0, 4, 2, 0, 1, 0);
    conv("v999",  999,  9, 9, 9, 1, 1, 0);
    conv("v1023", 1023, 9, 9, 9, 1, 1, 1);
    conv("v305",  305,  3, 0, 5, 1, 1, 0);
    conv("v100",  100,  1, 0, 0, 1, 1, 0);
    conv("v10",   10,   0, 1, 0, 0, 1, 0);
    conv("v1000", 1000, 9, 9, 9, 1, 1, 1);

    // Starts while busy are ignored; a start in the listo cycle is accepted.
    @(negedge CLK);
    binario = WIDTH'(123);
    iniciar = 1'b1;
    @(negedge CLK);                 // edge k sampled
    iniciar = 1'b0;
    binario = WIDTH'(456);
    repeat (2) @(negedge CLK);
    iniciar = 1'b1;                 // sampled at edge k+3
    @(negedge CLK);
    iniciar = 1'b0;
    repeat (3) @(negedge CLK);
    iniciar = 1'b1;                 // sampled at edge k+7
    @(negedge CLK);
    iniciar = 1'b0;
    check("busy_ocupado", int'(ocupado), 1);
    wait_listo(lat);
    check("ign_latency_rest", lat, 3);
    check_result("ign", 1, 2, 3, 1, 1, 0);
    iniciar = 1'b1;                 // sampled at edge k+11, the listo cycle
    @(negedge CLK);
    iniciar = 1'b0;
    check("b2b_hold_cen", int'(centenas), 1);
    wait_listo(lat);
    check("b2b_gap", lat + 1, 11);
    check_result("b2b", 4, 5, 6, 1, 1, 0);

    // Reset in the middle of a conversion.
    start(850);
    repeat (4) @(negedge CLK);
    #2 RESET_N = 1'b0;
    #1;
    check("mid_rst_cen", int'(centenas), 0);
    check("mid_rst_dec", int'(decenas), 0);
    check("mid_rst_uni", int'(unidades), 0);
    check("mid_rst_C", int'(C), 0);
    check("mid_rst_De", int'(De), 0);
    check("mid_rst_U", int'(U), 0);
    check("mid_rst_ovf", int'(sobrecarga), 0);
    check("mid_rst_ocupado", int'(ocupado), 0);
    check("mid_rst_listo", int'(listo), 0);
    repeat (2) @(negedge CLK);
    #2 RESET_N = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge CLK);
      check("aborted_no_listo", int'(listo), 0);
    end

    conv("v61", 61, 0, 6, 1, 0, 1, 0);

    repeat (2) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
